// File: rtl/cnt_pkg.sv
// Shared counter-library definitions: default width and JK cell command encodings.
// The JK cell, the up counter and the down counter all use these encodings.
package cnt_pkg;

  localparam int CNT_W_DEF = 4;

  // {J,K} pairs as seen by a JK cell.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_e;

  // Forces a cell to a given bit value on the next edge (J=b, K=~b).
  function automatic jk_cmd_e jk_load(input logic b);
    return b ? JK_SET : JK_RST;
  endfunction

endpackage

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop cell, falling-edge clocked, with synchronous active-high clear.
module jk_ff_sync
  import cnt_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q
);

  // NOTE: clocked state uses non-blocking assignments so every cell samples
  // the pre-edge value of its neighbours, as real flip-flops do.
  always_ff @(negedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else begin
      unique case (jk_cmd_e'({j, k}))
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TOG:  q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter built from JK cells, with cascade borrow (tc)
// and a registered done pulse. Optional auto-reload: define DOWNCNT_AUTORELOAD_EN.
module sync_down_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
);

  logic       zero;
  logic [1:0] cmd [WIDTH];

  assign zero = (q == '0);
  assign tc   = en & zero;

`ifdef DOWNCNT_AUTORELOAD_EN
  // Last loaded value; all-ones after clear so the default period is 2^WIDTH.
  logic [WIDTH-1:0] reload;

  always_ff @(negedge clk) begin
    if (clr)       reload <= '1;
    else if (load) reload <= din;
  end
`endif

  // A bit toggles when every lower bit is zero: that is where the borrow lands.
  // NOTE: every cmd element gets a default before any condition, so no latch
  // is inferred for the paths that leave a cell holding.
  always_comb begin
    logic borrow;
    borrow = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cmd[i] = JK_HOLD;
      if (load) begin
        cmd[i] = jk_load(din[i]);
      end else if (en) begin
`ifdef DOWNCNT_AUTORELOAD_EN
        if (zero)        cmd[i] = jk_load(reload[i]);
        else if (borrow) cmd[i] = JK_TOG;
`else
        if (borrow) cmd[i] = JK_TOG;
`endif
      end
      borrow = borrow & ~q[i];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff_sync u_cell (
      .clk (clk),
      .clr (clr),
      .j   (cmd[i][1]),
      .k   (cmd[i][0]),
      .q   (q[i])
    );
  end

  // done follows tc only on a plain count edge; load and clear suppress it.
  always_ff @(negedge clk) begin
    if (clr)       done <= 1'b0;
    else if (load) done <= 1'b0;
    else           done <= tc;
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: directed vector table, hand sequences
// for cascade / clear glitch / reload behaviour, and randomized model comparison.
module tb_sync_down_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;
`ifdef DOWNCNT_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam logic [W-1:0] WRAP5 = AR ? 4'd5 : 4'd15;

  logic         clk = 1'b0;
  logic         clr = 1'b0, en = 1'b0, load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] q;
  logic         tc, done;
  logic         hi_load = 1'b0;
  logic [W-1:0] hi_din = '0;
  logic [W-1:0] hi_q;
  logic         hi_tc, hi_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_down_counter #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .en(en), .load(load), .din(din),
    .q(q), .tc(tc), .done(done)
  );

  // Upper stage of a two-stage cascade, enabled by the lower stage's borrow.
  sync_down_counter #(.WIDTH(W)) dut_hi (
    .clk(clk), .clr(clr), .en(tc), .load(hi_load), .din(hi_din),
    .q(hi_q), .tc(hi_tc), .done(hi_done)
  );

  // Reference model: plain integer arithmetic on the counter value.
  int m_q, m_rl;
  bit m_done, m_valid = 1'b0;

  function automatic void model_edge(input bit c, e, l, input int d);
    if (c) begin
      m_q = 0; m_done = 1'b0; m_rl = MAXV; m_valid = 1'b1;
    end else if (l) begin
      m_q = d; m_done = 1'b0; m_rl = d; m_valid = 1'b1;
    end else if (e) begin
      m_done = (m_q == 0);
      if (m_q == 0) m_q = AR ? m_rl : MAXV;
      else          m_q = m_q - 1;
    end else begin
      m_done = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic         tc_pre, done_post;
  logic [W-1:0] q_post;

  // One clock: drive inputs after the rising edge, sample tc before the falling
  // (active) edge, sample q/done just after it.
  task automatic step(input logic c, e, l, input logic [W-1:0] d,
                      input logic hl = 1'b0, input logic [W-1:0] hd = '0);
    @(posedge clk); #1;
    clr = c; en = e; load = l; din = d; hi_load = hl; hi_din = hd;
    #1;
    tc_pre = tc;
    if (m_valid || !e) check("mdl_tc", tc, e && m_valid && m_q == 0);
    @(negedge clk); #1;
    model_edge(c, e, l, d);
    q_post = q; done_post = done;
    check("mdl_q", q, m_q);
    check("mdl_done", done, m_done);
  endtask

  typedef struct {
    logic         clr, en, load;
    logic [W-1:0] din;
    logic         tc;
    logic [W-1:0] q;
    logic         done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, e, l, input logic [W-1:0] d,
                              input logic t, input logic [W-1:0] eq, input logic dn);
    vec_t v;
    v.clr = c; v.en = e; v.load = l; v.din = d; v.tc = t; v.q = eq; v.done = dn;
    return v;
  endfunction

  initial begin
    int exp8, v8;

    // reset, then hold with en=0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    // load 5, count down through zero
    vecs.push_back(mk(0, 0, 1, 5, 0, 5, 0));
    for (int v = 4; v >= 0; v--) vecs.push_back(mk(0, 1, 0, 0, 0, v[W-1:0], 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, WRAP5, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, WRAP5 - 4'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, WRAP5 - 4'd1, 0));
    // load beats enable
    vecs.push_back(mk(0, 0, 1, 9, 0, 9, 0));
    vecs.push_back(mk(0, 1, 1, 2, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0));
    // clear mid-count with enable high
    vecs.push_back(mk(0, 0, 1, 7, 0, 7, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    // load at zero with en high: tc seen, but done suppressed
    vecs.push_back(mk(0, 1, 1, 3, 1, 3, 0));

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].load, vecs[i].din);
      check($sformatf("vec%0d_tc", i), tc_pre, vecs[i].tc);
      check($sformatf("vec%0d_q", i), q_post, vecs[i].q);
      check($sformatf("vec%0d_done", i), done_post, vecs[i].done);
    end

    // clr raised and dropped between falling edges must do nothing
    step(0, 0, 1, 7);
    @(posedge clk); #1;
    en = 1'b0; load = 1'b0; clr = 1'b1;
    #2 clr = 1'b0;
    @(negedge clk); #1;
    model_edge(0, 0, 0, 0);
    check("clr_glitch_q", q, 7);
    check("clr_glitch_done", done, 0);

    // two-stage cascade, both loaded with 0
    step(0, 0, 1, 0, 1'b1, 4'd0);
    check("casc_load", {hi_q, q}, 0);
    v8 = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 0, 0);
      exp8 = AR ? 0 : ((v8 - 1) & 8'hFF);
      check($sformatf("casc_%0d", k), {hi_q, q}, exp8);
      v8 = exp8;
    end

    // divide-by-(N+1) with N=3
    step(0, 0, 1, 3);
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, 0, 0);
      check($sformatf("div_q_%0d", k), q_post, AR ? (3 - (k % 4)) : ((3 - k) & MAXV));
      check($sformatf("div_done_%0d", k), done_post, AR ? (k % 4 == 0) : (k == 4));
    end

`ifdef DOWNCNT_AUTORELOAD_EN
    // reload value 0: continuous done
    step(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0);
      check("b2b_q", q_post, 0);
      check("b2b_done", done_post, 1);
    end
`endif

    // randomized traffic against the model
    step(1, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
